// File: rtl/branch_flush_ctrl_pkg.sv
// Shared definitions for the execute-stage branch/flush control slice:
// branch condition codes, FSM state encodings and the default target width.
package branch_flush_ctrl_pkg;

    localparam int ADDR_W_DEF = 16;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLTZ = 3'b010,
        BR_BGEZ = 3'b011,
        BR_BLEZ = 3'b100,
        BR_BGTZ = 3'b101,
        BR_J    = 3'b110,
        BR_RSVD = 3'b111
    } br_type_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Condition outcome for one branch type given the result's zero/sign flags.
    function automatic logic br_cond(input br_type_e br_type, input logic zero, input logic neg);
        logic hit;
        hit = 1'b0;
        case (br_type)
            BR_BEQ:  hit = zero;
            BR_BNE:  hit = !zero;
            BR_BLTZ: hit = neg;
            BR_BGEZ: hit = !neg;
            BR_BLEZ: hit = neg | zero;
            BR_BGTZ: hit = !neg & !zero;
            BR_J:    hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/branch_flush_ctrl_cond_eval.sv
// Purely combinational branch condition decoder (type + ALU result -> cond).
// Kept standalone so early-branch logic can reuse it.
module branch_cond_eval
    import branch_flush_ctrl_pkg::*;
(
    input  logic [2:0]  branchtype_i,
    input  logic [31:0] alu_result_i,
    output logic        cond_o
);

    logic       zero;
    logic       neg;
    logic [7:0] hit_vec;

    assign zero = (alu_result_i == 32'd0);
    assign neg  = alu_result_i[31];

    // Evaluate every condition in parallel, then select by the type code.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cond
            assign hit_vec[gi] = br_cond(br_type_e'(3'(gi)), zero, neg);
        end
    endgenerate

    assign cond_o = hit_vec[branchtype_i];

endmodule

// File: rtl/branch_flush_ctrl.sv
// Branch resolve, fetch redirect and wrong-path flush FSM for the end of execute.
// Optional saturating statistics counters enabled with BRANCH_STATS_EN.
module branch_flush_ctrl
    import branch_flush_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = 5,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branchen_i,
    input  logic [2:0]        branchtype_i,
    input  logic [ADDR_W-1:0] branchtarget_i,
    input  logic [31:0]       alu_result_i,
    output logic              pc_load_o,
    output logic [ADDR_W-1:0] pc_target_o,
    output logic              flush_o,
    output logic              busy_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]       taken_cnt_o,
    output logic [15:0]       flush_cyc_cnt_o
`endif
);

    localparam int CNT_W = $clog2(FLUSH_DEPTH + 1);

    state_e            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              pc_load_reg, pc_load_next;
    logic [ADDR_W-1:0] pc_target_reg, pc_target_next;
    logic              flush_reg, flush_next;
    logic              busy_reg, busy_next;
    logic              cond;
    logic              taken;

    branch_cond_eval u_cond (
        .branchtype_i (branchtype_i),
        .alu_result_i (alu_result_i),
        .cond_o       (cond)
    );

    // Anything presented while flushing is wrong-path, including the exit cycle.
    assign taken = branchen_i & cond & !stall_i & (state_reg == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            pc_load_reg   <= 1'b0;
            pc_target_reg <= '0;
            flush_reg     <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pc_load_reg   <= pc_load_next;
            pc_target_reg <= pc_target_next;
            flush_reg     <= flush_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pc_load_next   = 1'b0;
        pc_target_next = pc_target_reg;
        flush_next     = flush_reg;
        busy_next      = busy_reg;
        case (state_reg)
            ST_IDLE: begin
                flush_next = 1'b0;
                busy_next  = 1'b0;
                if (taken) begin
                    state_next     = ST_FLUSH;
                    cnt_next       = CNT_W'(FLUSH_DEPTH - 1);
                    pc_load_next   = 1'b1;
                    pc_target_next = branchtarget_i;
                    flush_next     = 1'b1;
                    busy_next      = 1'b1;
                end
            end
            ST_FLUSH: begin
                // pc_load stays a single-cycle pulse even if a stall lands on it.
                if (!stall_i) begin
                    if (cnt_reg == '0) begin
                        state_next = ST_IDLE;
                        flush_next = 1'b0;
                        busy_next  = 1'b0;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                flush_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign pc_load_o   = pc_load_reg;
    assign pc_target_o = pc_target_reg;
    assign flush_o     = flush_reg;
    assign busy_o      = busy_reg;

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt_reg;
    logic [15:0] flush_cyc_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_reg     <= '0;
            flush_cyc_cnt_reg <= '0;
        end else begin
            if (taken && (taken_cnt_reg != 16'hFFFF))
                taken_cnt_reg <= taken_cnt_reg + 1'b1;
            if (flush_reg && (flush_cyc_cnt_reg != 16'hFFFF))
                flush_cyc_cnt_reg <= flush_cyc_cnt_reg + 1'b1;
        end
    end

    assign taken_cnt_o     = taken_cnt_reg;
    assign flush_cyc_cnt_o = flush_cyc_cnt_reg;
`endif

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Self-checking bench for branch_flush_ctrl: directed plan steps plus random
// traffic against a cycle-level reference model of redirect/flush behaviour.
module tb_branch_flush_ctrl;

    localparam int DEPTH = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branchen_i;
    logic [2:0]  branchtype_i;
    logic [15:0] branchtarget_i;
    logic [31:0] alu_result_i;
    logic        pc_load_o;
    logic [15:0] pc_target_o;
    logic        flush_o;
    logic        busy_o;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt_o;
    logic [15:0] flush_cyc_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic        m_load;
    logic [15:0] m_tgt;
    int          m_left;
    int          m_tc;
    int          m_fc;
    int          flush_seen;
    int          loads_seen;

    always #5 clk = ~clk;

    branch_flush_ctrl #(.FLUSH_DEPTH(DEPTH), .ADDR_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branchen_i     (branchen_i),
        .branchtype_i   (branchtype_i),
        .branchtarget_i (branchtarget_i),
        .alu_result_i   (alu_result_i),
        .pc_load_o      (pc_load_o),
        .pc_target_o    (pc_target_o),
        .flush_o        (flush_o),
        .busy_o         (busy_o)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt_o     (taken_cnt_o),
        .flush_cyc_cnt_o (flush_cyc_cnt_o)
`endif
    );

    function automatic logic cond_ref(input logic [2:0] t, input logic [31:0] a);
        longint v;
        v = longint'($signed(a));
        case (t)
            3'd0: return v == 0;
            3'd1: return v != 0;
            3'd2: return v < 0;
            3'd3: return v >= 0;
            3'd4: return v <= 0;
            3'd5: return v > 0;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic step(input logic r, input logic s, input logic e, input logic [2:0] t,
                        input logic [15:0] tg, input logic [31:0] a);
        rst = r; stall_i = s; branchen_i = e; branchtype_i = t;
        branchtarget_i = tg; alu_result_i = a;
        @(posedge clk);
        if (r) begin
            m_load = 1'b0; m_tgt = '0; m_left = 0; m_tc = 0; m_fc = 0;
        end else begin
            if (m_left > 0 && m_fc < 16'hFFFF) m_fc++;
            if (m_left > 0) begin
                m_load = 1'b0;
                if (!s) m_left--;
            end else if (e && !s && cond_ref(t, a)) begin
                m_load = 1'b1;
                m_tgt  = tg;
                m_left = DEPTH;
                if (m_tc < 16'hFFFF) m_tc++;
            end else begin
                m_load = 1'b0;
            end
        end
        #1;
        if (flush_o === 1'b1) flush_seen++;
        if (pc_load_o === 1'b1) loads_seen++;
        $display("step rst=%0b stall=%0b en=%0b type=%0d tgt=%h alu=%h -> load=%0b tgt=%h flush=%0b busy=%0b",
                 r, s, e, t, tg, a, pc_load_o, pc_target_o, flush_o, busy_o);
        check("pc_load", 32'(pc_load_o), 32'(m_load));
        check("pc_target", 32'(pc_target_o), 32'(m_tgt));
        check("flush", 32'(flush_o), 32'(m_left > 0));
        check("busy", 32'(busy_o), 32'(m_left > 0));
`ifdef BRANCH_STATS_EN
        check("taken_cnt", 32'(taken_cnt_o), 32'(m_tc));
        check("flush_cyc_cnt", 32'(flush_cyc_cnt_o), 32'(m_fc));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h1);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  t;
        m_load = 0; m_tgt = 0; m_left = 0; m_tc = 0; m_fc = 0;
        flush_seen = 0; loads_seen = 0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 3'd6, 16'hFFFF, 32'h0);

        // BEQ taken: one redirect to 0040, flush for DEPTH cycles
        flush_seen = 0; loads_seen = 0;
        step(1'b0, 1'b0, 1'b1, 3'd0, 16'h0040, 32'h0);
        check("beq_target", 32'(pc_target_o), 32'h0040);
        idle(6);
        check("beq_flush_len", 32'(flush_seen), 32'(DEPTH));
        check("beq_loads", 32'(loads_seen), 32'd1);

        // BNE on zero not taken, then BLTZ on negative taken
        loads_seen = 0;
        step(1'b0, 1'b0, 1'b1, 3'd1, 16'h0050, 32'h0);
        check("bne_no_load", 32'(pc_load_o), 32'd0);
        step(1'b0, 1'b0, 1'b1, 3'd2, 16'h0080, 32'h8000_0000);
        check("bltz_load", 32'(pc_load_o), 32'd1);
        idle(6);

        // Taken J then wrong-path jumps every cycle of the flush
        flush_seen = 0; loads_seen = 0;
        step(1'b0, 1'b0, 1'b1, 3'd6, 16'h0100, 32'h5);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 3'd6, 16'h0200, 32'h5);
        check("j_loads", 32'(loads_seen), 32'd1);
        check("j_flush_len", 32'(flush_seen), 32'(DEPTH));
        check("j_target_kept", 32'(pc_target_o), 32'h0100);
        idle(2);

        // Stall of 3 cycles with counter at 2 stretches flush to 8 cycles
        flush_seen = 0;
        step(1'b0, 1'b0, 1'b1, 3'd0, 16'h0300, 32'h0);
        idle(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 32'h0);
        idle(4);
        check("stall_flush_len", 32'(flush_seen), 32'd8);

        // Reset on the 3rd flush cycle, then a normal BEQ redirect
        step(1'b0, 1'b0, 1'b1, 3'd0, 16'h0400, 32'h0);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0);
        check("rst_flush", 32'(flush_o), 32'd0);
        idle(1);
        step(1'b0, 1'b0, 1'b1, 3'd0, 16'h0500, 32'h0);
        check("post_rst_load", 32'(pc_load_o), 32'd1);
        idle(6);

        // Reserved type never taken; stalled taken branch is not evaluated
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 3'd7, 16'h0600, $urandom);
        step(1'b0, 1'b1, 1'b1, 3'd6, 16'h0700, 32'h0);
        check("stall_idle_no_load", 32'(pc_load_o), 32'd0);

        // Stats: three back-to-back taken branches from reset
        step(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, 3'd6, 16'(16'h0800 + k), 32'h0);
            idle(6);
        end
`ifdef BRANCH_STATS_EN
        check("stats_taken", 32'(taken_cnt_o), 32'd3);
        check("stats_flush", 32'(flush_cyc_cnt_o), 32'd15);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: a = 32'h0;
                1: a = 32'h8000_0000;
                2: a = 32'h1;
                3: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            t = 3'($urandom_range(0, 7));
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, t, 16'($urandom), a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
